// File: rtl/xif_dispatch_pkg.sv
// Shared owner-table entry type and opcode decode for the CV-X-IF accelerator dispatcher.
// Supports up to MAX_ACC channels; owner fields are sized for that maximum.
package xif_dispatch_pkg;

  localparam int MAX_ACC   = 8;
  localparam int ACC_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [ACC_IDX_W-1:0] owner;
  } owner_t;

  // Returns {hit, index} of the lowest channel below num whose opcode matches.
  function automatic logic [ACC_IDX_W:0] opcode_match(input logic [6:0] opcode,
                                                      input logic [MAX_ACC*7-1:0] list,
                                                      input int num);
    logic [ACC_IDX_W:0] r;
    r = '0;
    for (int i = MAX_ACC - 1; i >= 0; i--) begin
      if (i < num && list[7*i +: 7] == opcode) r = {1'b1, ACC_IDX_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/xif_rr_arbiter.sv
// Round-robin arbiter with combinational grant; the winner stays locked until ack, then the pointer moves past it.
// Zero latency; other requesters wait while a grant is held.
module xif_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_idx_q;
  logic          lock_q;
  logic [IW-1:0] rr_idx;
  logic          rr_vld;
  logic [IW:0]   pos;

  always_comb begin
    rr_vld = 1'b0;
    rr_idx = ptr_q;
    pos    = '0;
    // Walk from farthest to nearest so the requester closest to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (req[pos[IW-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = pos[IW-1:0];
      end
    end
  end

  assign gnt_vld = lock_q ? req[lock_idx_q] : rr_vld;
  assign gnt_idx = lock_q ? lock_idx_q : rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (gnt_vld && ack) begin
      lock_q <= 1'b0;
      ptr_q  <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end else if (gnt_vld) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/xif_accel_dispatcher.sv
// Steers CV-X-IF issue/register/commit traffic to NUM_ACC coprocessors and round-robins results back, zero added latency,
// backpressure passed straight from the owning channel. XIF_DISPATCH_PERF_EN adds issue and stall counters.
module xif_accel_dispatcher
  import xif_dispatch_pkg::*;
#(
  parameter int NUM_ACC         = 2,
  parameter int ID_WIDTH        = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_RS          = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter logic [NUM_ACC*7-1:0] ACC_OPCODES = {7'h0B, 7'h2B}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           core_issue_valid,
  output logic                           core_issue_ready,
  input  logic [31:0]                    core_issue_instr,
  input  logic [ID_WIDTH-1:0]            core_issue_id,
  output logic                           core_issue_accept,
  output logic                           core_issue_writeback,
  input  logic                           core_reg_valid,
  output logic                           core_reg_ready,
  input  logic [ID_WIDTH-1:0]            core_reg_id,
  input  logic [NUM_RS*DATA_WIDTH-1:0]   core_reg_rs,
  input  logic                           core_commit_valid,
  input  logic [ID_WIDTH-1:0]            core_commit_id,
  input  logic                           core_commit_kill,
  output logic                           core_result_valid,
  input  logic                           core_result_ready,
  output logic [ID_WIDTH-1:0]            core_result_id,
  output logic [DATA_WIDTH-1:0]          core_result_data,
  output logic [4:0]                     core_result_rd,
  output logic                           core_result_we,
  output logic [NUM_ACC-1:0]             acc_issue_valid,
  input  logic [NUM_ACC-1:0]             acc_issue_ready,
  output logic [NUM_ACC*32-1:0]          acc_issue_instr,
  output logic [NUM_ACC*ID_WIDTH-1:0]    acc_issue_id,
  input  logic [NUM_ACC-1:0]             acc_issue_accept,
  input  logic [NUM_ACC-1:0]             acc_issue_writeback,
  output logic [NUM_ACC-1:0]             acc_reg_valid,
  input  logic [NUM_ACC-1:0]             acc_reg_ready,
  output logic [NUM_ACC*ID_WIDTH-1:0]    acc_reg_id,
  output logic [NUM_ACC*NUM_RS*DATA_WIDTH-1:0] acc_reg_rs,
  output logic [NUM_ACC-1:0]             acc_commit_valid,
  output logic [NUM_ACC*ID_WIDTH-1:0]    acc_commit_id,
  output logic [NUM_ACC-1:0]             acc_commit_kill,
  input  logic [NUM_ACC-1:0]             acc_result_valid,
  output logic [NUM_ACC-1:0]             acc_result_ready,
  input  logic [NUM_ACC*ID_WIDTH-1:0]    acc_result_id,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]  acc_result_data,
  input  logic [NUM_ACC*5-1:0]           acc_result_rd,
  input  logic [NUM_ACC-1:0]             acc_result_we,
  output logic                           busy
`ifdef XIF_DISPATCH_PERF_EN
  ,
  output logic [NUM_ACC*32-1:0]          perf_issue_cnt,
  output logic [31:0]                    perf_stall_cnt
`endif
);

  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int GW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam logic [MAX_ACC*7-1:0] OP_LIST = (MAX_ACC*7)'(ACC_OPCODES);

  owner_t               owner_tbl [NUM_IDS];
  logic [CNT_W-1:0]     count_q;
  logic                 hit;
  logic [ACC_IDX_W-1:0] hit_idx;
  logic                 iss_live, res_live, stall, alloc;
  owner_t               reg_ent, cmt_ent;
  logic                 res_fire, kill_free, res_free, dbl_free;
  logic [1:0]           n_free;
  logic                 gnt_vld;
  logic [GW-1:0]        gnt_idx;

  assign {hit, hit_idx} = opcode_match(core_issue_instr[6:0], OP_LIST, NUM_ACC);
  assign iss_live = owner_tbl[core_issue_id].valid;
  assign res_live = owner_tbl[core_result_id].valid;
  assign reg_ent  = owner_tbl[core_reg_id];
  assign cmt_ent  = owner_tbl[core_commit_id];
  assign stall    = (count_q == CNT_W'(MAX_OUTSTANDING)) || iss_live;
  assign busy     = (count_q != '0);

  assign acc_issue_instr = {NUM_ACC{core_issue_instr}};
  assign acc_issue_id    = {NUM_ACC{core_issue_id}};
  assign acc_reg_id      = {NUM_ACC{core_reg_id}};
  assign acc_reg_rs      = {NUM_ACC{core_reg_rs}};
  assign acc_commit_id   = {NUM_ACC{core_commit_id}};
  assign acc_commit_kill = {NUM_ACC{core_commit_kill}};

  xif_rr_arbiter #(.N(NUM_ACC)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (acc_result_valid),
    .ack     (core_result_ready),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    acc_issue_valid      = '0;
    acc_reg_valid        = '0;
    acc_commit_valid     = '0;
    acc_result_ready     = '0;
    // Unclaimed opcodes are acknowledged immediately with accept=0.
    core_issue_ready     = core_issue_valid;
    core_issue_accept    = 1'b0;
    core_issue_writeback = 1'b0;
    core_reg_ready       = busy;
    core_result_valid    = gnt_vld;
    core_result_id       = '0;
    core_result_data     = '0;
    core_result_rd       = '0;
    core_result_we       = 1'b0;
    for (int c = 0; c < NUM_ACC; c++) begin
      if (hit && hit_idx == ACC_IDX_W'(c)) begin
        acc_issue_valid[c]   = core_issue_valid & ~stall;
        core_issue_ready     = acc_issue_ready[c] & ~stall;
        core_issue_accept    = acc_issue_accept[c];
        core_issue_writeback = acc_issue_writeback[c];
      end
      if (reg_ent.valid && reg_ent.owner == ACC_IDX_W'(c)) begin
        acc_reg_valid[c] = core_reg_valid;
        core_reg_ready   = acc_reg_ready[c];
      end
      if (cmt_ent.valid && cmt_ent.owner == ACC_IDX_W'(c))
        acc_commit_valid[c] = core_commit_valid;
      if (gnt_vld && gnt_idx == GW'(c)) begin
        acc_result_ready[c] = core_result_ready;
        core_result_id      = acc_result_id[c*ID_WIDTH +: ID_WIDTH];
        core_result_data    = acc_result_data[c*DATA_WIDTH +: DATA_WIDTH];
        core_result_rd      = acc_result_rd[c*5 +: 5];
        core_result_we      = acc_result_we[c];
      end
    end
  end

  assign alloc     = core_issue_valid & core_issue_ready & core_issue_accept & hit;
  assign res_fire  = gnt_vld & core_result_ready;
  assign kill_free = core_commit_valid & core_commit_kill & cmt_ent.valid;
  assign res_free  = res_fire & res_live;
  // A kill and a result naming the same ID release a single entry.
  assign dbl_free  = kill_free & res_free & (core_commit_id != core_result_id);
  assign n_free    = dbl_free ? 2'd2 : {1'b0, kill_free | res_free};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < NUM_IDS; i++) owner_tbl[i] <= '0;
    end else begin
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(n_free);
      if (kill_free) owner_tbl[core_commit_id] <= '0;
      if (res_free)  owner_tbl[core_result_id] <= '0;
      if (alloc)     owner_tbl[core_issue_id]  <= '{valid: 1'b1, owner: hit_idx};
    end
  end

`ifdef XIF_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (core_issue_valid && stall && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      for (int c = 0; c < NUM_ACC; c++) begin
        if (alloc && hit_idx == ACC_IDX_W'(c) && perf_issue_cnt[c*32 +: 32] != '1)
          perf_issue_cnt[c*32 +: 32] <= perf_issue_cnt[c*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xif_accel_dispatcher.sv
// Directed bench for xif_accel_dispatcher: channel 0 owns opcode 0x0B, channel 1 owns 0x2B.
module tb_xif_accel_dispatcher;

  localparam int NA = 2, IDW = 4, DW = 64, NRS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic core_issue_valid, core_issue_ready, core_issue_accept, core_issue_writeback;
  logic [31:0] core_issue_instr;
  logic [IDW-1:0] core_issue_id, core_reg_id, core_commit_id, core_result_id;
  logic core_reg_valid, core_reg_ready;
  logic [NRS*DW-1:0] core_reg_rs;
  logic core_commit_valid, core_commit_kill;
  logic core_result_valid, core_result_ready, core_result_we;
  logic [DW-1:0] core_result_data;
  logic [4:0] core_result_rd;
  logic [NA-1:0] acc_issue_valid, acc_issue_ready, acc_issue_accept, acc_issue_writeback;
  logic [NA*32-1:0] acc_issue_instr;
  logic [NA*IDW-1:0] acc_issue_id, acc_reg_id, acc_commit_id, acc_result_id;
  logic [NA-1:0] acc_reg_valid, acc_reg_ready, acc_commit_valid, acc_commit_kill;
  logic [NA*NRS*DW-1:0] acc_reg_rs;
  logic [NA-1:0] acc_result_valid, acc_result_ready, acc_result_we;
  logic [NA*DW-1:0] acc_result_data;
  logic [NA*5-1:0] acc_result_rd;
  logic busy;
`ifdef XIF_DISPATCH_PERF_EN
  logic [NA*32-1:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  xif_accel_dispatcher #(
    .NUM_ACC(NA), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .NUM_RS(NRS),
    .MAX_OUTSTANDING(8), .ACC_OPCODES({7'h2B, 7'h0B})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_issue_valid(core_issue_valid), .core_issue_ready(core_issue_ready),
    .core_issue_instr(core_issue_instr), .core_issue_id(core_issue_id),
    .core_issue_accept(core_issue_accept), .core_issue_writeback(core_issue_writeback),
    .core_reg_valid(core_reg_valid), .core_reg_ready(core_reg_ready),
    .core_reg_id(core_reg_id), .core_reg_rs(core_reg_rs),
    .core_commit_valid(core_commit_valid), .core_commit_id(core_commit_id),
    .core_commit_kill(core_commit_kill),
    .core_result_valid(core_result_valid), .core_result_ready(core_result_ready),
    .core_result_id(core_result_id), .core_result_data(core_result_data),
    .core_result_rd(core_result_rd), .core_result_we(core_result_we),
    .acc_issue_valid(acc_issue_valid), .acc_issue_ready(acc_issue_ready),
    .acc_issue_instr(acc_issue_instr), .acc_issue_id(acc_issue_id),
    .acc_issue_accept(acc_issue_accept), .acc_issue_writeback(acc_issue_writeback),
    .acc_reg_valid(acc_reg_valid), .acc_reg_ready(acc_reg_ready),
    .acc_reg_id(acc_reg_id), .acc_reg_rs(acc_reg_rs),
    .acc_commit_valid(acc_commit_valid), .acc_commit_id(acc_commit_id),
    .acc_commit_kill(acc_commit_kill),
    .acc_result_valid(acc_result_valid), .acc_result_ready(acc_result_ready),
    .acc_result_id(acc_result_id), .acc_result_data(acc_result_data),
    .acc_result_rd(acc_result_rd), .acc_result_we(acc_result_we),
    .busy(busy)
`ifdef XIF_DISPATCH_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_issue(input logic [6:0] op, input logic [IDW-1:0] id);
    core_issue_valid = 1'b1;
    core_issue_instr = {25'h0, op};
    core_issue_id    = id;
    tick();
    core_issue_valid = 1'b0;
  endtask

  task automatic do_result(input int ch, input logic [IDW-1:0] id);
    acc_result_valid = '0;
    acc_result_valid[ch] = 1'b1;
    acc_result_id[ch*IDW +: IDW] = id;
    core_result_ready = 1'b1;
    tick();
    acc_result_valid  = '0;
    core_result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    core_issue_valid = 0; core_issue_instr = '0; core_issue_id = '0;
    core_reg_valid = 0; core_reg_id = '0; core_reg_rs = '0;
    core_commit_valid = 0; core_commit_id = '0; core_commit_kill = 0;
    core_result_ready = 0;
    acc_issue_ready = '0; acc_issue_accept = '0; acc_issue_writeback = '0;
    acc_reg_ready = '0; acc_result_valid = '0; acc_result_id = '0;
    acc_result_data = '0; acc_result_rd = '0; acc_result_we = '0;
    #12;
    total++; if (core_issue_ready !== 1'b0) begin bad++; $display("FAIL reset_issue_ready: got %b want 0", core_issue_ready); end
    total++; if (core_reg_ready !== 1'b0) begin bad++; $display("FAIL reset_reg_ready: got %b want 0", core_reg_ready); end
    total++; if (core_result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid: got %b want 0", core_result_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    acc_issue_ready = 2'b11; acc_issue_accept = 2'b11; acc_issue_writeback = 2'b10;
    tick();
  endtask

  task automatic test_issue_result();
    core_issue_valid = 1'b1; core_issue_instr = 32'h0000_002B; core_issue_id = 4'd3;
    settle();
    total++; if (acc_issue_valid !== 2'b10) begin bad++; $display("FAIL issue_route: got %b want 10", acc_issue_valid); end
    total++; if ({core_issue_ready, core_issue_accept, core_issue_writeback} !== 3'b111) begin bad++; $display("FAIL issue_hs: got %b want 111", {core_issue_ready, core_issue_accept, core_issue_writeback}); end
    total++; if (acc_issue_instr[63:32] !== 32'h0000_002B) begin bad++; $display("FAIL issue_instr: got %h want 0000002b", acc_issue_instr[63:32]); end
    tick();
    core_issue_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL issue_busy: got %b want 1", busy); end
    core_reg_valid = 1'b1; core_reg_id = 4'd3; acc_reg_ready = 2'b10;
    settle();
    total++; if (acc_reg_valid !== 2'b10 || core_reg_ready !== 1'b1) begin bad++; $display("FAIL reg_route: got %b/%b want 10/1", acc_reg_valid, core_reg_ready); end
    acc_reg_ready = 2'b01;
    settle();
    total++; if (core_reg_ready !== 1'b0) begin bad++; $display("FAIL reg_owner_ready: got %b want 0", core_reg_ready); end
    core_reg_valid = 1'b0;
    acc_result_valid = 2'b10; acc_result_id[7:4] = 4'd3;
    acc_result_data[127:64] = 64'hDEAD_BEEF_0000_0003; acc_result_rd[9:5] = 5'd7; acc_result_we = 2'b10;
    core_result_ready = 1'b1;
    settle();
    total++; if (core_result_valid !== 1'b1 || core_result_id !== 4'd3) begin bad++; $display("FAIL result_id: got %b/%0d want 1/3", core_result_valid, core_result_id); end
    total++; if (core_result_data !== 64'hDEAD_BEEF_0000_0003 || core_result_rd !== 5'd7 || core_result_we !== 1'b1) begin bad++; $display("FAIL result_fields: got %h/%0d/%b", core_result_data, core_result_rd, core_result_we); end
    total++; if (acc_result_ready !== 2'b10) begin bad++; $display("FAIL result_ready: got %b want 10", acc_result_ready); end
    tick();
    acc_result_valid = '0; core_result_ready = 1'b0; acc_result_we = '0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL result_free_busy: got %b want 0", busy); end
  endtask

  task automatic test_no_match();
    core_issue_valid = 1'b1; core_issue_instr = 32'h0000_0033; core_issue_id = 4'd6;
    settle();
    total++; if (core_issue_ready !== 1'b1 || core_issue_accept !== 1'b0) begin bad++; $display("FAIL nomatch_hs: got %b/%b want 1/0", core_issue_ready, core_issue_accept); end
    total++; if (acc_issue_valid !== 2'b00) begin bad++; $display("FAIL nomatch_route: got %b want 00", acc_issue_valid); end
    tick();
    core_issue_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nomatch_busy: got %b want 0", busy); end
  endtask

  task automatic test_rr_alternate();
    logic [IDW-1:0] exp_id;
    logic [DW-1:0]  exp_data;
    acc_result_valid = 2'b11;
    acc_result_id = {4'd2, 4'd1};
    acc_result_data = {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    for (int i = 0; i < 8; i++) begin
      core_result_ready = (i % 2 == 1);
      exp_id   = ((i / 2) % 2 == 0) ? 4'd1 : 4'd2;
      exp_data = ((i / 2) % 2 == 0) ? 64'hAAAA_0000_0000_0001 : 64'hBBBB_0000_0000_0002;
      settle();
      total++; if (core_result_id !== exp_id || core_result_data !== exp_data) begin bad++; $display("FAIL rr_cycle%0d: got %0d/%h want %0d/%h", i, core_result_id, core_result_data, exp_id, exp_data); end
      tick();
    end
    acc_result_valid = '0; core_result_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int id = 0; id < 8; id++) do_issue(7'h0B, IDW'(id));
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", busy); end
    core_issue_valid = 1'b1; core_issue_instr = 32'h0000_000B; core_issue_id = 4'd8;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (core_issue_ready !== 1'b0 || acc_issue_valid !== 2'b00) begin bad++; $display("FAIL full_stall%0d: got %b/%b want 0/00", i, core_issue_ready, acc_issue_valid); end
      tick();
    end
    acc_result_valid = 2'b01; acc_result_id[3:0] = 4'd0; core_result_ready = 1'b1;
    settle();
    total++; if (core_issue_ready !== 1'b0) begin bad++; $display("FAIL full_free_cycle: got %b want 0", core_issue_ready); end
    tick();
    acc_result_valid = '0; core_result_ready = 1'b0;
    settle();
    total++; if (core_issue_ready !== 1'b1 || acc_issue_valid !== 2'b01) begin bad++; $display("FAIL full_resume: got %b/%b want 1/01", core_issue_ready, acc_issue_valid); end
    tick();
    core_issue_valid = 1'b0;
    for (int id = 1; id <= 8; id++) do_result(0, IDW'(id));
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_drain: got %b want 0", busy); end
  endtask

  task automatic test_kill_and_result();
    do_issue(7'h2B, 4'd5);
    do_issue(7'h0B, 4'd2);
    core_commit_valid = 1'b1; core_commit_id = 4'd5; core_commit_kill = 1'b1;
    acc_result_valid = 2'b01; acc_result_id[3:0] = 4'd2; core_result_ready = 1'b1;
    settle();
    total++; if (acc_commit_valid !== 2'b10 || acc_commit_kill[1] !== 1'b1) begin bad++; $display("FAIL kill_route: got %b/%b want 10/1", acc_commit_valid, acc_commit_kill[1]); end
    tick();
    core_commit_valid = 1'b0; core_commit_kill = 1'b0; acc_result_valid = '0; core_result_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_double_free: got %b want 0", busy); end
    core_commit_valid = 1'b1; core_commit_id = 4'd9;
    settle();
    total++; if (acc_commit_valid !== 2'b00) begin bad++; $display("FAIL commit_invalid_drop: got %b want 00", acc_commit_valid); end
    tick();
    core_commit_valid = 1'b0;
  endtask

  task automatic test_dup_id();
`ifdef XIF_DISPATCH_PERF_EN
    logic [31:0] stall0, iss0;
    stall0 = perf_stall_cnt;
    iss0   = perf_issue_cnt[31:0];
`endif
    do_issue(7'h0B, 4'd4);
    core_reg_valid = 1'b1; core_reg_id = 4'd7;
    settle();
    total++; if (core_reg_ready !== 1'b1 || acc_reg_valid !== 2'b00) begin bad++; $display("FAIL reg_drop: got %b/%b want 1/00", core_reg_ready, acc_reg_valid); end
    core_reg_valid = 1'b0;
    core_commit_valid = 1'b1; core_commit_id = 4'd4;
    settle();
    total++; if (acc_commit_valid !== 2'b01) begin bad++; $display("FAIL commit_route: got %b want 01", acc_commit_valid); end
    tick();
    core_commit_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL commit_keep: got %b want 1", busy); end
    core_issue_valid = 1'b1; core_issue_instr = 32'h0000_000B; core_issue_id = 4'd4;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (core_issue_ready !== 1'b0 || acc_issue_valid !== 2'b00) begin bad++; $display("FAIL dup_stall%0d: got %b/%b want 0/00", i, core_issue_ready, acc_issue_valid); end
      tick();
    end
    acc_result_valid = 2'b01; acc_result_id[3:0] = 4'd4; core_result_ready = 1'b1;
    tick();
    acc_result_valid = '0; core_result_ready = 1'b0;
    settle();
    total++; if (core_issue_ready !== 1'b1) begin bad++; $display("FAIL dup_resume: got %b want 1", core_issue_ready); end
    tick();
    core_issue_valid = 1'b0;
`ifdef XIF_DISPATCH_PERF_EN
    total++; if (perf_stall_cnt - stall0 !== 32'd4) begin bad++; $display("FAIL perf_stall: got %0d want 4", perf_stall_cnt - stall0); end
    total++; if (perf_issue_cnt[31:0] - iss0 !== 32'd2) begin bad++; $display("FAIL perf_issue: got %0d want 2", perf_issue_cnt[31:0] - iss0); end
`endif
    do_result(0, 4'd4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dup_drain: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_issue_result();
    test_rr_alternate();
    test_no_match();
    test_full();
    test_kill_and_result();
    test_dup_id();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
